// File: rtl/ppu_vga_pkg.sv
// Shared PPU/VGA constants and the read-pipeline control payload.
package ppu_vga_pkg;

  localparam int unsigned NES_W = 256;
  localparam int unsigned NES_H = 240;
  localparam int unsigned VGA_W = 640;
  localparam int unsigned VGA_H = 480;
  localparam int unsigned PAL_W = 5;

  localparam logic [PAL_W-1:0] BACKDROP_IDX = 5'd0;

  typedef logic [PAL_W-1:0] pal_t;

  // Control bits that travel alongside the RAM read.
  typedef struct packed {
    logic vld;
    logic in_range;
    logic hit;
  } rd_ctl_t;

endpackage

// File: rtl/ppu_line_buffer_if.sv
// PPU write side, VGA read side and status of the scanline buffer.
interface ppu_line_buffer_if;
  import ppu_vga_pkg::*;

  logic       pix_we;
  logic [8:0] xIdx;
  logic [8:0] yIdx;
  pal_t       pal_index;
  logic       rd_en;
  logic [9:0] x_addr;
  logic [9:0] y_addr;
  pal_t       pal_out;
  logic       pal_valid;
  logic       underrun;
  logic       underrun_clr;
  logic       line_done;

  modport master (
    output pix_we, xIdx, yIdx, pal_index, rd_en, x_addr, y_addr, underrun_clr,
    input  pal_out, pal_valid, underrun, line_done
  );

  modport slave (
    input  pix_we, xIdx, yIdx, pal_index, rd_en, x_addr, y_addr, underrun_clr,
    output pal_out, pal_valid, underrun, line_done
  );

endinterface

// File: rtl/ppu_line_buffer_line_ram.sv
// Simple dual-port RAM with registered read; a same-address read returns old data.
module line_ram #(
  parameter  int unsigned DEPTH = 8192,
  parameter  int unsigned WIDTH = 5,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clock) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
    rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/ppu_line_buffer.sv
// Scanline ring buffer: PPU pixels in, 2x-doubled VGA reads out, with
// per-slot completeness/tag tracking so overruns return the backdrop.
module ppu_line_buffer
  import ppu_vga_pkg::*;
#(
  parameter int unsigned LINES    = 32,
  parameter int unsigned X_OFFSET = 1,
  parameter pal_t        BACKDROP = BACKDROP_IDX
) (
  input  logic               clock,
  input  logic               reset,
  ppu_line_buffer_if.slave   bus
);

  localparam int unsigned SLOT_W = $clog2(LINES);
  localparam int unsigned TAG_W  = 8 - SLOT_W;
  localparam int unsigned AW     = SLOT_W + 8;

  logic [8:0]        wx;
  logic              wr_acc;
  logic              wr_first;
  logic              wr_last;
  logic [SLOT_W-1:0] w_slot;
  logic [TAG_W-1:0]  w_tag;

  logic [LINES-1:0]  valid_q, valid_d;
  logic [TAG_W-1:0]  tag_q [LINES];
  logic [TAG_W-1:0]  tag_d [LINES];
  logic              line_done_q, line_done_d;

  logic [7:0]        sx;
  logic [7:0]        sy;
  logic [SLOT_W-1:0] r_slot;
  logic [AW-1:0]     raddr;
  rd_ctl_t           s1_ctl_q, s1_ctl_d;

  pal_t              ram_rdata;
  pal_t              pal_out_q, pal_out_d;
  logic              pal_valid_q, pal_valid_d;
  logic              underrun_q, underrun_d;

  // Write-side decode: the PPU x counter runs one pixel ahead of its data.
  always_comb begin
    wx       = bus.xIdx - 9'(X_OFFSET);
    wr_acc   = bus.pix_we && (wx < 9'(NES_W)) && (bus.yIdx < 9'(NES_H));
    wr_first = wr_acc && (wx[7:0] == 8'h00);
    wr_last  = wr_acc && (wx[7:0] == 8'hFF);
    w_slot   = bus.yIdx[SLOT_W-1:0];
    w_tag    = bus.yIdx[7:SLOT_W];
  end

  // Slot bookkeeping: a slot is invalid from its first pixel until its last.
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    if (wr_first) begin
      valid_d[w_slot] = 1'b0;
      tag_d[w_slot]   = w_tag;
    end
    if (wr_last) begin
      valid_d[w_slot] = 1'b1;
    end
    line_done_d = wr_last;
  end

  // Read stage 0: hit is judged on the slot state before this cycle's write.
  always_comb begin
    sx                = bus.x_addr[8:1];
    sy                = bus.y_addr[8:1];
    r_slot            = sy[SLOT_W-1:0];
    raddr             = {r_slot, sx};
    s1_ctl_d          = '0;
    s1_ctl_d.vld      = bus.rd_en;
    s1_ctl_d.in_range = (bus.x_addr < 10'(2 * NES_W)) && (bus.y_addr < 10'(VGA_H));
    s1_ctl_d.hit      = s1_ctl_d.in_range && valid_q[r_slot] &&
                        (tag_q[r_slot] == sy[7:SLOT_W]);
  end

  line_ram #(
    .DEPTH (LINES * NES_W),
    .WIDTH (PAL_W)
  ) u_ram (
    .clock (clock),
    .we    (wr_acc),
    .waddr ({w_slot, wx[7:0]}),
    .wdata (bus.pal_index),
    .raddr (raddr),
    .rdata (ram_rdata)
  );

  // Output stage; a clear wins over a same-cycle underrun set.
  always_comb begin
    pal_out_d   = pal_out_q;
    pal_valid_d = s1_ctl_q.vld;
    underrun_d  = underrun_q;
    if (s1_ctl_q.vld) begin
      pal_out_d = s1_ctl_q.hit ? ram_rdata : BACKDROP;
      if (s1_ctl_q.in_range && !s1_ctl_q.hit) begin
        underrun_d = 1'b1;
      end
    end
    if (bus.underrun_clr) begin
      underrun_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q     <= '0;
      for (int i = 0; i < int'(LINES); i++) begin
        tag_q[i] <= '0;
      end
      line_done_q <= 1'b0;
      s1_ctl_q    <= '0;
      pal_out_q   <= BACKDROP;
      pal_valid_q <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      tag_q       <= tag_d;
      line_done_q <= line_done_d;
      s1_ctl_q    <= s1_ctl_d;
      pal_out_q   <= pal_out_d;
      pal_valid_q <= pal_valid_d;
      underrun_q  <= underrun_d;
    end
  end

  assign bus.pal_out   = pal_out_q;
  assign bus.pal_valid = pal_valid_q;
  assign bus.underrun  = underrun_q;
  assign bus.line_done = line_done_q;

endmodule

// File: tb/tb_ppu_line_buffer.sv
// Randomised bench for ppu_line_buffer against a line-level behavioural model.
module tb_ppu_line_buffer;

  localparam int unsigned LINES = 32;
  localparam logic [4:0]  BD    = 5'd0;

  logic clock = 1'b0;
  logic reset;

  ppu_line_buffer_if bus();

  ppu_line_buffer #(
    .LINES    (LINES),
    .X_OFFSET (1),
    .BACKDROP (BD)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;
  int ld_cnt = 0;

  task automatic cmp(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: per-slot "which source line, is it complete" plus a pixel array.
  logic [4:0] m_mem [LINES*256];
  int         m_line [LINES];
  bit         m_done [LINES];
  logic [4:0] e_pal;
  bit         e_valid, e_under, e_ld;
  bit         p_v, p_set;
  logic [4:0] p_data;
  bit         chk_en = 1'b0;

  always @(posedge clock) begin
    int xi, yi, xa, ya, wx, s, sx, sy;
    bit inr, hit, wacc;
    if (reset) begin
      e_pal = BD; e_valid = 0; e_under = 0; e_ld = 0;
      p_v = 0; p_set = 0; p_data = BD;
      for (int i = 0; i < int'(LINES); i++) begin
        m_line[i] = i;
        m_done[i] = 0;
      end
      chk_en = 1'b1;
    end else begin
      xi = int'(bus.xIdx); yi = int'(bus.yIdx);
      xa = int'(bus.x_addr); ya = int'(bus.y_addr);
      wx = (xi + 511) % 512;
      wacc = bus.pix_we && (wx < 256) && (yi < 240);
      e_valid = p_v;
      if (p_v) e_pal = p_data;
      if (bus.underrun_clr) e_under = 0;
      else if (p_v && p_set) e_under = 1;
      e_ld = wacc && (wx == 255);
      p_v = bus.rd_en;
      inr = (xa < 512) && (ya < 480);
      sx = xa / 2; sy = ya / 2; s = sy % int'(LINES);
      hit = inr && m_done[s] && (m_line[s] == sy);
      p_data = hit ? m_mem[s*256 + sx] : BD;
      p_set = inr && !hit;
      if (wacc) begin
        s = yi % int'(LINES);
        m_mem[s*256 + wx] = bus.pal_index;
        if (wx == 0) begin
          m_line[s] = yi;
          m_done[s] = 0;
        end
        if (wx == 255) m_done[s] = 1;
      end
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      cmp("pal_out",   32'(bus.pal_out),   32'(e_pal));
      cmp("pal_valid", 32'(bus.pal_valid), 32'(e_valid));
      cmp("underrun",  32'(bus.underrun),  32'(e_under));
      cmp("line_done", 32'(bus.line_done), 32'(e_ld));
      if (bus.line_done === 1'b1) ld_cnt++;
    end
  end

  task automatic quiet();
    bus.pix_we = 0; bus.rd_en = 0; bus.underrun_clr = 0;
  endtask

  task automatic idle(int n);
    repeat (n) begin
      @(negedge clock);
      quiet();
    end
  endtask

  // One PPU scanline xIdx=1..stop_at; rnd adds random data, junk strobes and VGA reads.
  task automatic write_line(int y, bit rnd, int stop_at = 256);
    int x = 1;
    int ry;
    while (x <= stop_at) begin
      @(negedge clock);
      quiet();
      if (rnd) begin
        bus.rd_en = ($urandom_range(0, 2) == 0);
        bus.x_addr = 10'($urandom_range(0, 700));
        ry = y - int'($urandom_range(0, 36));
        if (ry < 0) ry += 240;
        if ($urandom_range(0, 9) == 0) bus.y_addr = 10'($urandom_range(0, 1023));
        else bus.y_addr = 10'(2 * ry + int'($urandom_range(0, 1)));
        bus.underrun_clr = ($urandom_range(0, 15) == 0);
      end
      if (rnd && $urandom_range(0, 7) == 0) begin
        bus.pix_we = 1'($urandom_range(0, 1));
        bus.pal_index = 5'($urandom);
        case ($urandom_range(0, 2))
          0: begin bus.xIdx = 9'($urandom_range(257, 511)); bus.yIdx = 9'(y); end
          1: begin bus.xIdx = 9'd0; bus.yIdx = 9'(y); end
          default: begin bus.xIdx = 9'(x); bus.yIdx = 9'($urandom_range(240, 511)); end
        endcase
      end else begin
        bus.pix_we = 1;
        bus.xIdx = 9'(x);
        bus.yIdx = 9'(y);
        bus.pal_index = rnd ? 5'($urandom) : 5'(x - 1 + y);
        x++;
      end
    end
    @(negedge clock);
    quiet();
  endtask

  task automatic read_px(int xa, int ya, output logic [4:0] pal, output logic v, output logic u);
    @(negedge clock);
    quiet();
    bus.rd_en = 1; bus.x_addr = 10'(xa); bus.y_addr = 10'(ya);
    @(negedge clock);
    quiet();
    @(negedge clock);
    pal = bus.pal_out; v = bus.pal_valid; u = bus.underrun;
  endtask

  task automatic clr_under();
    @(negedge clock);
    quiet();
    bus.underrun_clr = 1;
    @(negedge clock);
    quiet();
  endtask

  initial begin
    logic [4:0] pal;
    logic v, u;
    int ld0;
    quiet();
    bus.xIdx = '0; bus.yIdx = '0; bus.pal_index = '0;
    bus.x_addr = '0; bus.y_addr = '0;
    reset = 1;
    repeat (3) @(negedge clock);
    cmp("rst_pal_out", 32'(bus.pal_out), 32'(0));
    cmp("rst_underrun", 32'(bus.underrun), 32'(0));
    reset = 0;

    // Line 0, then a doubled read of source pixel 5.
    ld0 = ld_cnt;
    write_line(0, 0);
    idle(2);
    cmp("t1_line_done_cnt", 32'(ld_cnt - ld0), 32'(1));
    read_px(10, 1, pal, v, u);
    cmp("t1_pal", 32'(pal), 32'(5));
    cmp("t1_valid", 32'(v), 32'(1));
    cmp("t1_underrun", 32'(u), 32'(0));

    // Unwritten slot.
    read_px(0, 2, pal, v, u);
    cmp("t2_pal", 32'(pal), 32'(BD));
    cmp("t2_underrun", 32'(u), 32'(1));
    clr_under();
    cmp("t2_clr", 32'(bus.underrun), 32'(0));

    // Turnover: slot 3 restarted by line 35 while sy=3 is read at the same address.
    write_line(1, 0); write_line(2, 0); write_line(3, 0);
    @(negedge clock);
    quiet();
    bus.pix_we = 1; bus.xIdx = 9'd1; bus.yIdx = 9'd35; bus.pal_index = 5'd31;
    bus.rd_en = 1; bus.x_addr = 10'd0; bus.y_addr = 10'd6;
    @(negedge clock);
    quiet();
    @(negedge clock);
    cmp("t5_old_pal", 32'(bus.pal_out), 32'(3));
    cmp("t5_no_underrun", 32'(bus.underrun), 32'(0));
    read_px(0, 6, pal, v, u);
    cmp("t5_next_pal", 32'(pal), 32'(BD));
    cmp("t5_next_underrun", 32'(u), 32'(1));
    clr_under();

    // Ring wrap: lines 0..39 over 32 slots.
    for (int y = 0; y < 40; y++) write_line(y, 0);
    read_px(0, 2, pal, v, u);
    cmp("t3_stale_pal", 32'(pal), 32'(BD));
    cmp("t3_stale_underrun", 32'(u), 32'(1));
    clr_under();
    read_px(20, 66, pal, v, u);
    cmp("t3_l33_pal", 32'(pal), 32'(11));
    cmp("t3_l33_underrun", 32'(u), 32'(0));

    // Out-of-range reads.
    read_px(600, 10, pal, v, u);
    cmp("t4_x_pal", 32'(pal), 32'(BD));
    cmp("t4_x_valid", 32'(v), 32'(1));
    cmp("t4_x_underrun", 32'(u), 32'(0));
    read_px(100, 480, pal, v, u);
    cmp("t4_y_pal", 32'(pal), 32'(BD));
    cmp("t4_y_underrun", 32'(u), 32'(0));

    // Reset in the middle of line 5.
    for (int y = 0; y < 5; y++) write_line(y, 0);
    read_px(0, 300, pal, v, u);
    read_px(20, 8, pal, v, u);
    cmp("t6_pre_pal", 32'(pal), 32'(14));
    cmp("t6_pre_underrun", 32'(u), 32'(1));
    write_line(5, 0, 100);
    reset = 1;
    @(negedge clock);
    cmp("t6_rst_pal", 32'(bus.pal_out), 32'(BD));
    cmp("t6_rst_valid", 32'(bus.pal_valid), 32'(0));
    cmp("t6_rst_underrun", 32'(bus.underrun), 32'(0));
    cmp("t6_rst_line_done", 32'(bus.line_done), 32'(0));
    @(negedge clock);
    reset = 0;
    for (int y = 0; y < 5; y++) begin
      clr_under();
      read_px(20, 2 * y, pal, v, u);
      cmp("t6_post_pal", 32'(pal), 32'(BD));
      cmp("t6_post_underrun", 32'(u), 32'(1));
    end
    clr_under();

    // Random traffic across vblank and a frame wrap.
    for (int y = 200; y < 262; y++) write_line(y, 1);
    for (int y = 0; y < 70; y++) write_line(y, 1);
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
